sine_phase_sequencer: RTL
=========================

// Module: sine_phase_sequencer
// PURPOSE
//   Phase-accumulator control stage that sits directly upstream of the 7-bit ripple adder in the
//   DigitalSine path. It drives the adder with the current phase and the step word, then registers
//   the sum back as the new phase on each sample tick. It also outputs the phase, quadrant and
//   wrap indication to the downstream sine lookup. Its FSM provides phase-coherent start/stop and
//   step-word changes.
// PARAMETERS
//   PHASE_W   7   phase/step width; must match adder width (7)
//   DIV_W     8   width of sample-tick divider
// PORTS
//   clk           in   1        single system clock, rising edge
//   rst_n         in   1        synchronous active-low reset
//   en            in   1        run request (level)
//   div_in        in   DIV_W    tick period minus 1 (0 = tick every cycle); sampled at reload
//   step_in       in   PHASE_W  requested phase step (frequency word)
//   step_load     in   1        1-cycle request to adopt step_in
//   step_ack      out  1        1-cycle pulse: pending step applied
//   add_a         out  PHASE_W  to adder A: current phase register
//   add_b         out  PHASE_W  to adder B: active step (0 when not stepping)
//   add_s         in   PHASE_W  from adder S: add_a+add_b mod 2^PHASE_W (combinational)
//   phase         out  PHASE_W  registered phase
//   quadrant      out  2        phase[PHASE_W-1:PHASE_W-2]
//   sample_valid  out  1        1-cycle pulse: phase updated this cycle
//   wrap          out  1        1-cycle pulse with sample_valid when phase overflowed
//   busy          out  1        high in RUN or STOPPING
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=IDLE, phase=0, active step=0, pending flag=0, div count=0;
//     all pulses, busy and add_b are 0.
//   Divider: in RUN/STOPPING, cnt==0 -> tick, cnt<=div_in; else cnt<=cnt-1. In IDLE, cnt is held at 0,
//     so the first tick occurs on the first cycle in RUN.
//   Stepping: on tick, phase<=add_s; sample_valid=1 on the next cycle. add_b=active step only in
//     RUN/STOPPING.
//   Wrap: wrap=1 when add_s < add_a (unsigned) at the tick, i.e. carry-out (adder has no Cout port).
//     Step 0 never wraps.
//   FSM states:
//     IDLE -> RUN when en=1.
//     RUN -> STOPPING when en=0.
//     STOPPING -> RUN when en=1 again (no phase disturbance).
//     STOPPING -> IDLE on a wrapping tick. On that tick, phase<=0 instead of add_s, so the output
//       always stops at a zero crossing. sample_valid and wrap still pulse.
//     STOPPING with active step=0 -> IDLE on the next tick with phase<=0 (avoids deadlock).
//   Step change:
//     Request: step_load sets pending and captures step_in. A later step_load before application
//       overwrites the captured value (last wins).
//     Apply in IDLE: on the next cycle. Apply in RUN/STOPPING: only on a wrapping tick, taking effect
//       from the following tick.
//     step_ack pulses with application.
//     step_load in the same cycle as a wrapping tick is captured but applied at the next wrap.
//   Latency: en rise -> first sample_valid = 2 cycles (IDLE->RUN, tick, register).
//   Reset mid-operation: immediate return to reset values. The pending step is discarded and
//     step_ack is not issued.
//   Width: all arithmetic is mod 2^PHASE_W; no internal adder (the external adder performs the sum).
// STRUCTURE
//   Shared package dsine_pkg: PHASE_W=7, state encoding (IDLE=2'd0, RUN=2'd1, STOPPING=2'd2).
//   One natural sub-module: sine_tick_div (DIV_W down-counter with reload, enable, tick out).
//   Top-level test harness instantiates sine_phase_sequencer + adder in a closed loop.
// TESTING
//   1 Reset: drive rst_n=0 for 2 clk mid-RUN with phase=37 -> next cycle phase=0, busy=0, all
//     pulses 0.
//   2 div_in=0, step 16 loaded in IDLE, en=1 -> step_ack the cycle after load; phase 16,32,...,112
//     on successive cycles; 0 with wrap=1 on the 8th sample.
//   3 div_in=3, step=5 -> sample_valid every 4th cycle; phase 5,10,15,...; wrap at 125->2.
//   4 Stop: step=20, en dropped at phase=60 -> busy stays 1; phase 80,100,120, then 0 with wrap=1;
//     state IDLE, add_b=0.
//   5 Coherent change: RUN step=8, step_load step_in=3 at phase=40 -> steps of 8 continue until wrap
//     (120->0); step_ack there; then 3,6,9...
//   6 Edge: step=0 in STOPPING -> IDLE after one tick, phase=0. step_load twice (9 then 11) before
//     wrap -> 11 applied, single ack.

Source files
------------

// File: rtl/dsine_pkg.sv
// Shared definitions for the DigitalSine phase path: widths, sequencer state encoding and
// carry detection for an adder that exposes no carry-out.
package dsine_pkg;

    localparam int unsigned PHASE_W = 7;
    localparam int unsigned DIV_W   = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopping = 2'd2
    } seq_state_e;

    // A modular sum smaller than its first operand means the addition carried out.
    function automatic logic phase_wrapped(input logic [PHASE_W-1:0] sum,
                                           input logic [PHASE_W-1:0] base);
        return sum < base;
    endfunction

endpackage

// File: rtl/dsine_ripple_adder.sv
// Ripple-carry adder of the DigitalSine phase path: s = a + b mod 2^W, no carry-out port.
module dsine_ripple_adder #(
    parameter int unsigned W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);

    logic [W-1:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (i < W - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/sine_tick_div.sv
// Sample-tick divider: fires when the count is zero, then reloads div_in; parked at zero
// while not running so the first running cycle always ticks.
module sine_tick_div #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = div_in;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sine_phase_sequencer.sv
// Phase-accumulator control for the DigitalSine path: feeds the external adder, registers its
// sum on each sample tick, and sequences start/stop and step changes at zero crossings.
module sine_phase_sequencer #(
    parameter int unsigned PHASE_W = dsine_pkg::PHASE_W,
    parameter int unsigned DIV_W   = dsine_pkg::DIV_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DIV_W-1:0]   div_in,
    input  logic [PHASE_W-1:0] step_in,
    input  logic               step_load,
    output logic               step_ack,
    output logic [PHASE_W-1:0] add_a,
    output logic [PHASE_W-1:0] add_b,
    input  logic [PHASE_W-1:0] add_s,
    output logic [PHASE_W-1:0] phase,
    output logic [1:0]         quadrant,
    output logic               sample_valid,
    output logic               wrap,
    output logic               busy
);

    import dsine_pkg::*;

    seq_state_e         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [PHASE_W-1:0] pend_q, pend_d;
    logic               pending_q, pending_d;
    logic               sv_q, sv_d;
    logic               wrap_q, wrap_d;
    logic               ack_q, ack_d;
    logic               run;
    logic               tick;
    logic               carry;
    logic               stop_now;

    assign run = (state_q != StIdle);

    sine_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .div_in (div_in),
        .tick   (tick)
    );

    assign add_a = phase_q;
    assign add_b = run ? step_q : '0;
    assign carry = tick && phase_wrapped(add_s, phase_q);

    // A zero step never carries, so stopping on any tick avoids waiting forever.
    assign stop_now = (state_q == StStopping) && !en && tick && (carry || (step_q == '0));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        step_d    = step_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        sv_d      = tick;
        wrap_d    = carry;
        ack_d     = 1'b0;

        if (step_load) begin
            pending_d = 1'b1;
            pend_d    = step_in;
        end

        unique case (state_q)
            StIdle: begin
                if (step_load) begin
                    step_d    = step_in;
                    pending_d = 1'b0;
                    ack_d     = 1'b1;
                end else if (pending_q) begin
                    step_d    = pend_q;
                    pending_d = 1'b0;
                    ack_d     = 1'b1;
                end
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StStopping;
                end
            end
            StStopping: begin
                if (en) begin
                    state_d = StRun;
                end else if (stop_now) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tick) begin
            phase_d = stop_now ? '0 : add_s;
        end

        // A request arriving on the wrapping tick itself waits for the next wrap.
        if (carry && pending_q && !step_load) begin
            step_d    = pend_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            step_q    <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            sv_q      <= 1'b0;
            wrap_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            sv_q      <= sv_d;
            wrap_q    <= wrap_d;
            ack_q     <= ack_d;
        end
    end

    assign phase        = phase_q;
    assign quadrant     = phase_q[PHASE_W-1 -: 2];
    assign sample_valid = sv_q;
    assign wrap         = wrap_q;
    assign step_ack     = ack_q;
    assign busy         = run;

endmodule
